grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//   Producer side of the GRF write port (Regwrite/A3/WD/PC). Merges W-stage pipeline results with
//   results from late, multi-cycle sources (MDU, load-miss path) onto the single GRF write port.
//   Late results wait in a small in-order FIFO and drain in cycles where the pipeline has no write.
//   Provides pending-write queries so decode can stall on registers with an outstanding late write.
// PARAMETERS
//   DEPTH   4   late-result FIFO entries; power of two, >= 2
//   PTR_W   2   log2(DEPTH)
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low; 0 = reset
//   pipe_we     in   1      W-stage write request; no backpressure
//   pipe_a3     in   5      W-stage destination register
//   pipe_wd     in   32     W-stage write data
//   pipe_pc     in   32     W-stage instruction PC
//   late_valid  in   1      late source has a result
//   late_ready  out  1      FIFO can accept; transfer on late_valid & late_ready
//   late_a3     in   5      late destination register
//   late_wd     in   32     late write data
//   late_pc     in   32     late instruction PC
//   q_a1        in   5      decode query address, rs
//   q_a2        in   5      decode query address, rt
//   q_busy1     out  1      live pending late write to q_a1
//   q_busy2     out  1      live pending late write to q_a2
//   grf_we      out  1      drives GRF Regwrite
//   grf_a3      out  5      drives GRF A3
//   grf_wd      out  32     drives GRF WD
//   grf_pc      out  32     drives GRF PC
//   fifo_cnt    out  PTR_W+1  occupied entries, killed entries included
// BEHAVIOUR
//   - Reset (async, reset=0): FIFO empty, all entry valid bits 0, grf_we/a3/wd/pc = 0, fifo_cnt = 0.
//   - grf_* are registered: the value selected in cycle N appears on grf_* in N+1. The GRF forwards
//     internally, so the output register is visible to readers.
//   - Selection each cycle, in priority order:
//     1. pipe_we & pipe_a3 != 0: issue pipe write.
//     2. Otherwise, if FIFO not empty: pop head; issue it if its live bit is set, else grf_we = 0.
//     3. Otherwise: grf_we = 0, grf_a3/wd/pc hold their last values.
//   - pipe_we with pipe_a3 == 0 is dropped, leaving the slot free for a FIFO pop.
//   - late_ready = !full, where full is computed from the registered count. No push while full,
//     even if a pop happens in the same cycle.
//   - A late result with late_a3 == 0 is accepted and dropped; no entry is created.
//   - Accepted late result: enqueued at tail with live = 1. Minimum latency late_valid -> grf_we is
//     2 cycles (FIFO cycle + output register). No bypass path.
//   - Push and pop in the same cycle are both performed; count is unchanged.
//   - Pointers wrap modulo DEPTH.
//   - Kill rule: an issued pipe write to register X clears live on every FIFO entry whose a3 == X.
//     This stops an older late write from clobbering a younger pipe write.
//   - A late push to X in the same cycle as a pipe write to X is not killed; the late result is younger.
//   - q_busyN = OR over live FIFO entries with a3 == q_aN, OR (late_valid & late_ready &
//     late_a3 == q_aN). Always 0 when q_aN == 0.
//   - Live entries to the same register drain in push order.
//   - Reset asserted mid-drain discards all queued entries. No partial write is issued.
// CONFIGURATION
//   WB_TRACE_EN defined: on each rising clk where the registered grf_we = 1, print
//     $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd); killed pops and dropped $0 writes print nothing.
//   WB_TRACE_EN undefined: no $display; logic is otherwise identical.
// TESTING
//   1. Reset low while FIFO holds 3 entries -> fifo_cnt = 0, grf_we = 0, late_ready = 1 immediately.
//   2. Pipe idle; late push $5 = 0x1234 in cycle 0 -> grf_we = 1, grf_a3 = 5, grf_wd = 0x1234 in cycle 2.
//   3. pipe_we = 1 every cycle; push 4 late results -> late_ready = 0 and fifo_cnt = 4. Then pipe idle
//      -> the 4 entries issue in order on 4 consecutive cycles.
//   4. FIFO holds $8 = 0xAAAA; pipe writes $8 = 0xBBBB -> q_busy for $8 drops to 0, the killed pop
//      issues no write, and the final GRF $8 = 0xBBBB.
//   5. pipe_a3 = 0 with pipe_we = 1 and FIFO non-empty -> the FIFO head issues that cycle; no $0 write.
//   6. Full FIFO with simultaneous pop and late_valid -> push refused; fifo_cnt goes 4 -> 3; next cycle
//      late_ready = 1.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// GRF write-port arbiter bus: W-stage request, late-result handshake,
// decode pending-write queries and the registered GRF write port.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface grf_wb_arbiter_if #(
    parameter int unsigned PTR_W = 2
);
    // W-stage write request
    logic          pipe_we;
    logic [4:0]    pipe_a3;
    logic [31:0]   pipe_wd;
    logic [31:0]   pipe_pc;
    // Late (multi-cycle) result handshake
    logic          late_valid;
    logic          late_ready;
    logic [4:0]    late_a3;
    logic [31:0]   late_wd;
    logic [31:0]   late_pc;
    // Decode pending-write queries
    logic [4:0]    q_a1;
    logic [4:0]    q_a2;
    logic          q_busy1;
    logic          q_busy2;
    // GRF write port
    logic          grf_we;
    logic [4:0]    grf_a3;
    logic [31:0]   grf_wd;
    logic [31:0]   grf_pc;
    logic [PTR_W:0] fifo_cnt;

    modport master (
        output pipe_we, pipe_a3, pipe_wd, pipe_pc,
        output late_valid, late_a3, late_wd, late_pc,
        output q_a1, q_a2,
        input  late_ready, q_busy1, q_busy2,
        input  grf_we, grf_a3, grf_wd, grf_pc, fifo_cnt
    );

    modport slave (
        input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
        input  late_valid, late_a3, late_wd, late_pc,
        input  q_a1, q_a2,
        output late_ready, q_busy1, q_busy2,
        output grf_we, grf_a3, grf_wd, grf_pc, fifo_cnt
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter. W-stage writes have priority; late results queue in an
// in-order FIFO and drain in cycles where the pipeline does not write. An issued
// pipe write kills older queued writes to the same register.
// Optional: define WB_TRACE_EN to print each committed GRF write.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic             clk,
    input logic             reset,
    grf_wb_arbiter_if.slave bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // FIFO storage and state
    logic [4:0]       a3_q [DEPTH];
    logic [4:0]       a3_d [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [31:0]      wd_d [DEPTH];
    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      pc_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Output register
    logic             grf_we_q, grf_we_d;
    logic [4:0]       grf_a3_q, grf_a3_d;
    logic [31:0]      grf_wd_q, grf_wd_d;
    logic [31:0]      grf_pc_q, grf_pc_d;

    logic full, empty, pipe_issue, pop, late_acc, push;
    logic busy1, busy2;

    // Per-cycle selection and handshake decisions
    always_comb begin
        full       = (cnt_q == FULL_CNT);
        empty      = (cnt_q == '0);
        pipe_issue = bus.pipe_we && (bus.pipe_a3 != 5'd0);
        pop        = !pipe_issue && !empty;
        // Full is judged on the registered count, so a same-cycle pop never frees a slot.
        late_acc   = bus.late_valid && !full;
        push       = late_acc && (bus.late_a3 != 5'd0);
    end

    // FIFO next state: kill, pop, push and occupancy
    always_comb begin
        a3_d   = a3_q;
        wd_d   = wd_q;
        pc_d   = pc_q;
        live_d = live_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pipe_issue) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a3_q[i] == bus.pipe_a3) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        // Free slots always carry live = 0 so the busy query can ignore occupancy.
        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end
        // Applied after the kill loop: a same-cycle push is younger than the pipe write.
        if (push) begin
            a3_d[tail_q]   = bus.late_a3;
            wd_d[tail_q]   = bus.late_wd;
            pc_d[tail_q]   = bus.late_pc;
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // GRF port next state; address/data hold when nothing is issued
    always_comb begin
        grf_we_d = 1'b0;
        grf_a3_d = grf_a3_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        if (pipe_issue) begin
            grf_we_d = 1'b1;
            grf_a3_d = bus.pipe_a3;
            grf_wd_d = bus.pipe_wd;
            grf_pc_d = bus.pipe_pc;
        end else if (pop && live_q[head_q]) begin
            grf_we_d = 1'b1;
            grf_a3_d = a3_q[head_q];
            grf_wd_d = wd_q[head_q];
            grf_pc_d = pc_q[head_q];
        end
    end

    // Pending-write queries: live queued entries plus a result being accepted now
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (a3_q[i] == bus.q_a1)) busy1 = 1'b1;
            if (live_q[i] && (a3_q[i] == bus.q_a2)) busy2 = 1'b1;
        end
        if (late_acc && (bus.late_a3 == bus.q_a1)) busy1 = 1'b1;
        if (late_acc && (bus.late_a3 == bus.q_a2)) busy2 = 1'b1;
        if (bus.q_a1 == 5'd0) busy1 = 1'b0;
        if (bus.q_a2 == 5'd0) busy2 = 1'b0;
    end

    // State registers; reset drops every queued entry without issuing it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                a3_q[i] <= '0;
                wd_q[i] <= '0;
                pc_q[i] <= '0;
            end
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            grf_we_q <= 1'b0;
            grf_a3_q <= '0;
            grf_wd_q <= '0;
            grf_pc_q <= '0;
        end else begin
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            pc_q     <= pc_d;
            live_q   <= live_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            grf_we_q <= grf_we_d;
            grf_a3_q <= grf_a3_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
        end
    end

    assign bus.late_ready = !full;
    assign bus.q_busy1    = busy1;
    assign bus.q_busy2    = busy2;
    assign bus.grf_we     = grf_we_q;
    assign bus.grf_a3     = grf_a3_q;
    assign bus.grf_wd     = grf_wd_q;
    assign bus.grf_pc     = grf_pc_q;
    assign bus.fifo_cnt   = cnt_q;

`ifdef WB_TRACE_EN
    // Commit trace of every write presented to the GRF
    always @(posedge clk) begin
        if (grf_we_q) begin
            $display("@%h: $%d <= %h", grf_pc_q, grf_a3_q, grf_wd_q);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter. Expected GRF writes are queued as stimulus is
// driven and compared, in order, by a monitor whenever the DUT presents a write.
module tb_grf_wb_arbiter;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    logic [31:0] shadow [32];

    grf_wb_arbiter_if #(.PTR_W(2)) bus ();

    grf_wb_arbiter #(
        .DEPTH(4),
        .PTR_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        wr_t w;
        w.a3 = a3;
        w.wd = wd;
        w.pc = pc;
        exp_q.push_back(w);
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                            input logic [31:0] pc);
        bus.pipe_we = we;
        bus.pipe_a3 = a3;
        bus.pipe_wd = wd;
        bus.pipe_pc = pc;
    endtask

    task automatic set_late(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                            input logic [31:0] pc);
        bus.late_valid = v;
        bus.late_a3    = a3;
        bus.late_wd    = wd;
        bus.late_pc    = pc;
    endtask

    // Scoreboard: every presented write must match the oldest expected write
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        if (bus.grf_we === 1'b1) begin
            got.a3 = bus.grf_a3;
            got.wd = bus.grf_wd;
            got.pc = bus.grf_pc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed=%0h expected=none", got);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                assert (got === want) else begin
                    errors++;
                    $error("FAIL write_order: observed=%0h expected=%0h", got, want);
                end
            end
            shadow[bus.grf_a3] = bus.grf_wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        reset = 1'b1;
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        bus.q_a1 = 5'd0;
        bus.q_a2 = 5'd0;
        #1 reset = 1'b0;
        #1;
        check("rst_grf_we", 64'(bus.grf_we), 64'd0);
        check("rst_cnt", 64'(bus.fifo_cnt), 64'd0);
        check("rst_ready", 64'(bus.late_ready), 64'd1);
        check("rst_grf_a3", 64'(bus.grf_a3), 64'd0);
        #20;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single late push with idle pipe: visible two edges later
        bus.q_a1 = 5'd5;
        set_late(1'b1, 5'd5, 32'h1234, 32'h100);
        exp_wr(5'd5, 32'h1234, 32'h100);
        #1;
        check("lat_busy_incoming", 64'(bus.q_busy1), 64'd1);
        check("lat_ready", 64'(bus.late_ready), 64'd1);
        tick();
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("lat_cnt1", 64'(bus.fifo_cnt), 64'd1);
        check("lat_we_c1", 64'(bus.grf_we), 64'd0);
        check("lat_busy_queued", 64'(bus.q_busy1), 64'd1);
        tick();
        check("lat_we_c2", 64'(bus.grf_we), 64'd1);
        check("lat_a3_c2", 64'(bus.grf_a3), 64'd5);
        check("lat_wd_c2", 64'(bus.grf_wd), 64'h1234);
        check("lat_cnt0", 64'(bus.fifo_cnt), 64'd0);
        check("lat_busy_clear", 64'(bus.q_busy1), 64'd0);
        tick();
        check("lat_we_idle", 64'(bus.grf_we), 64'd0);
        check("lat_a3_hold", 64'(bus.grf_a3), 64'd5);

        // Fill under continuous pipe writes, then drain in order
        for (int i = 0; i < 4; i++) begin
            set_pipe(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 32'h200 + 32'(4 * i));
            set_late(1'b1, 5'(16 + i), 32'h2000 + 32'(i), 32'h300 + 32'(4 * i));
            exp_wr(5'(i + 1), 32'h1000 + 32'(i), 32'h200 + 32'(4 * i));
            tick();
        end
        check("full_cnt", 64'(bus.fifo_cnt), 64'd4);
        check("full_ready", 64'(bus.late_ready), 64'd0);
        set_pipe(1'b1, 5'd6, 32'h1006, 32'h210);
        set_late(1'b1, 5'd20, 32'h2004, 32'h310);
        exp_wr(5'd6, 32'h1006, 32'h210);
        tick();
        check("full_hold_cnt", 64'(bus.fifo_cnt), 64'd4);
        check("full_pipe_a3", 64'(bus.grf_a3), 64'd6);
        // Pop with a refused push: count 4 -> 3
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) exp_wr(5'(16 + i), 32'h2000 + 32'(i), 32'h300 + 32'(4 * i));
        #1;
        check("popfull_ready_before", 64'(bus.late_ready), 64'd0);
        tick();
        check("popfull_cnt", 64'(bus.fifo_cnt), 64'd3);
        check("popfull_ready_after", 64'(bus.late_ready), 64'd1);
        check("drain_a3_0", 64'(bus.grf_a3), 64'd16);
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("drain_we", 64'(bus.grf_we), 64'd1);
            check("drain_a3", 64'(bus.grf_a3), 64'(16 + i));
        end
        check("drain_cnt", 64'(bus.fifo_cnt), 64'd0);
        tick();
        check("drain_we_end", 64'(bus.grf_we), 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Kill: younger pipe write to $8 cancels queued $8
        bus.q_a1 = 5'd8;
        set_pipe(1'b1, 5'd1, 32'h11, 32'h400);
        set_late(1'b1, 5'd8, 32'hAAAA, 32'h500);
        exp_wr(5'd1, 32'h11, 32'h400);
        tick();
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        set_pipe(1'b1, 5'd8, 32'hBBBB, 32'h404);
        exp_wr(5'd8, 32'hBBBB, 32'h404);
        #1;
        check("kill_busy_before", 64'(bus.q_busy1), 64'd1);
        check("kill_cnt_before", 64'(bus.fifo_cnt), 64'd1);
        tick();
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("kill_busy_after", 64'(bus.q_busy1), 64'd0);
        check("kill_cnt_kept", 64'(bus.fifo_cnt), 64'd1);
        check("kill_pipe_wd", 64'(bus.grf_wd), 64'hBBBB);
        tick();
        check("kill_pop_we", 64'(bus.grf_we), 64'd0);
        check("kill_pop_cnt", 64'(bus.fifo_cnt), 64'd0);
        check("kill_wd_hold", 64'(bus.grf_wd), 64'hBBBB);
        tick();
        check("kill_final_r8", 64'(shadow[8]), 64'hBBBB);

        // Same-cycle push and pipe write to $9: the late result survives
        bus.q_a2 = 5'd9;
        set_pipe(1'b1, 5'd9, 32'h9999, 32'h408);
        set_late(1'b1, 5'd9, 32'hCCCC, 32'h600);
        exp_wr(5'd9, 32'h9999, 32'h408);
        tick();
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        set_pipe(1'b1, 5'd2, 32'h22, 32'h40C);
        exp_wr(5'd2, 32'h22, 32'h40C);
        #1;
        check("same_busy", 64'(bus.q_busy2), 64'd1);
        tick();
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        exp_wr(5'd9, 32'hCCCC, 32'h600);
        tick();
        check("same_we", 64'(bus.grf_we), 64'd1);
        check("same_wd", 64'(bus.grf_wd), 64'hCCCC);
        tick();
        check("same_final_r9", 64'(shadow[9]), 64'hCCCC);

        // Pipe write to $0 leaves the slot to the FIFO head
        set_pipe(1'b1, 5'd3, 32'h33, 32'h410);
        set_late(1'b1, 5'd7, 32'hDDDD, 32'h700);
        exp_wr(5'd3, 32'h33, 32'h410);
        tick();
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        set_pipe(1'b1, 5'd0, 32'hEEEE, 32'h414);
        exp_wr(5'd7, 32'hDDDD, 32'h700);
        tick();
        check("zero_we", 64'(bus.grf_we), 64'd1);
        check("zero_a3", 64'(bus.grf_a3), 64'd7);
        check("zero_wd", 64'(bus.grf_wd), 64'hDDDD);
        check("zero_cnt", 64'(bus.fifo_cnt), 64'd0);
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("zero_we_idle", 64'(bus.grf_we), 64'd0);

        // Late result to $0 is accepted but never queued
        bus.q_a1 = 5'd0;
        set_late(1'b1, 5'd0, 32'hFFFF, 32'h800);
        #1;
        check("late0_ready", 64'(bus.late_ready), 64'd1);
        check("late0_busy", 64'(bus.q_busy1), 64'd0);
        tick();
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        check("late0_cnt", 64'(bus.fifo_cnt), 64'd0);
        tick();
        check("late0_we", 64'(bus.grf_we), 64'd0);
        check("late0_r0", 64'(shadow[0]), 64'd0);

        // Reset while three entries are queued
        for (int i = 0; i < 3; i++) begin
            set_pipe(1'b1, 5'(10 + i), 32'h3000 + 32'(i), 32'h900 + 32'(4 * i));
            set_late(1'b1, 5'(24 + i), 32'h4000 + 32'(i), 32'hA00 + 32'(4 * i));
            exp_wr(5'(10 + i), 32'h3000 + 32'(i), 32'h900 + 32'(4 * i));
            tick();
        end
        set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        set_late(1'b0, 5'd0, 32'h0, 32'h0);
        check("rstq_cnt3", 64'(bus.fifo_cnt), 64'd3);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rstq_cnt", 64'(bus.fifo_cnt), 64'd0);
        check("rstq_we", 64'(bus.grf_we), 64'd0);
        check("rstq_ready", 64'(bus.late_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstq_no_write", 64'(bus.grf_we), 64'd0);
        end
        check("rstq_cnt_after", 64'(bus.fifo_cnt), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
